// File: rtl/spi_write_controller.sv
// spi_write_controller: serialises {1, addr, data} as one 16-bit mode-0 SPI write frame.
// sclk is clk divided by 2*CLK_DIV; copi shifts on the same edge that drops sclk.
module spi_write_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [15:0]   shreg, shreg_n;
    logic          done_n;
    logic          phase_end;

    assign phase_end = cnt == LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            done    <= done_n;
        end
    end

    // Every phase lasts CLK_DIV cycles; the divider restarts at each phase boundary.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        done_n    = 1'b0;
        cnt_n     = (state == IDLE || phase_end) ? '0 : cnt + 1'b1;
        case (state)
            IDLE: if (start) begin
                shreg_n   = {1'b1, addr, data};
                bit_cnt_n = '0;
                state_n   = SETUP;
            end
            SETUP: if (phase_end) state_n = HIGH;
            HIGH: if (phase_end) begin
                if (bit_cnt != 4'd15) begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    shreg_n   = {shreg[14:0], 1'b0};
                    state_n   = LOW;
                end else begin
                    shreg_n   = '0;
                    state_n   = HOLD;
                end
            end
            LOW:  if (phase_end) state_n = HIGH;
            HOLD: if (phase_end) state_n = GAP;
            GAP: if (phase_end) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = state != IDLE;
    assign sclk = state == HIGH;
    assign ncs  = state == IDLE || state == GAP;
    assign copi = shreg[15];
endmodule
